draw_sprite: RTL and testbench
==============================

Name: draw_sprite

Overview:
- Parametrised sprite blitter for the VGA frame-buffer path.
- On a start pulse it latches an anchor (x, y) and walks an SPR_W x SPR_H sprite ROM in row-major order.
- For each visible pixel it emits one write (X_out, Y_out, Color_out, writeEn) to the shared VGA write mux.
- Pixels outside the screen are clipped. A per-draw completion counter replaces the fixed 8x8 single-sprite drawers.

Parameters:
- SPR_W, 8, sprite width in pixels (1..64)
- SPR_H, 8, sprite height in pixels (1..64)
- ADDR_W, 6, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- COLOR_W, 12, pixel colour width
- SCREEN_W, 320, visible width; X_out range 0..SCREEN_W-1
- SCREEN_H, 240, visible height; Y_out range 0..SCREEN_H-1
- TKEY, 12'h000, transparent colour key (used only with the optional feature)

Ports:
- clk, input, 1, system clock
- resetn, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle request to draw; sampled only in IDLE
- x_init, input, 9, sprite anchor X (top-left); sampled when start is accepted
- y_init, input, 8, sprite anchor Y (top-left); sampled when start is accepted
- clear_count, input, 1, synchronous clear of draw_count
- rom_addr, output, ADDR_W, sprite ROM address; row*SPR_W + col
- rom_q, input, COLOR_W, ROM data; valid exactly 1 cycle after rom_addr
- X_out, output, 9, pixel X
- Y_out, output, 8, pixel Y
- Color_out, output, COLOR_W, pixel colour
- writeEn, output, 1, pixel write strobe
- busy, output, 1, high in every state except IDLE
- draw_done, output, 1, one-cycle pulse when a draw completes
- draw_count, output, 8, number of completed draws, mod 256

Behaviour:
- Reset (async, resetn=0):
  - FSM to IDLE
  - col, row, rom_addr, X_out, Y_out, Color_out, draw_count all 0
  - writeEn, busy, draw_done all 0
  - Reset mid-draw abandons the draw with no further writes and no draw_done.
- States: IDLE, ADDR, DATA, WRITE, DONE.
- IDLE:
  - On start=1: latch x_init/y_init, col=0, row=0, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - Drive rom_addr = row*SPR_W + col.
  - Register X_out = x_lat + col, 10-bit intermediate, truncated to 9 bits on output.
  - Register Y_out = y_lat + row, 9-bit intermediate, truncated to 8 bits on output.
  - Next state DATA.
- DATA:
  - ROM latency cycle; register Color_out <= rom_q at the end of the cycle.
  - Also register clip = (x intermediate >= SCREEN_W) | (y intermediate >= SCREEN_H).
  - Next state WRITE.
- WRITE:
  - writeEn = !clip for exactly this cycle; X_out, Y_out and Color_out are stable and valid.
  - Advance: col++. If col == SPR_W-1: col=0, row++.
  - If the last pixel (row == SPR_H-1 and col == SPR_W-1) was just written, go to DONE; else go to ADDR.
- DONE:
  - draw_done=1, draw_count++ (wraps 255 -> 0).
  - Next state IDLE.
- Timing:
  - Exactly 3 cycles per pixel.
  - From the start-accept edge to draw_done high: 3*SPR_W*SPR_H + 1 cycles.
- writeEn, busy and draw_done are Moore outputs of the state register (registered state, combinational decode).
- start while busy is ignored; it is not queued.
- clear_count:
  - Clears draw_count on the next edge.
  - If coincident with the DONE increment, clear wins and the result is 0.
- Clipping never changes the pixel count or timing; only writeEn is suppressed.
- Anchor wrap-around is not performed: pixels past the screen edge are dropped, not wrapped.

Optional Feature:
- Macro DRAW_SPRITE_TRANSPARENT_EN.
- When defined: in WRITE, writeEn = !clip && (Color_out != TKEY). Transparent pixels still take 3 cycles and still advance the address.
- When undefined: TKEY is ignored and every unclipped pixel is written.

Test Plan:
- SPR_W=8, SPR_H=8, ROM[i]=i, start with x_init=10, y_init=20:
  - 64 writeEn pulses, in order (10,20)..(17,27), each with Color_out=i.
  - draw_done on cycle 193 after start; draw_count=1.
- x_init=316, y_init=236, 8x8:
  - Only cols 0..3 and rows 0..3 are written: 16 writes.
  - draw_done is still at cycle 193.
- start pulsed again at cycle 50 of a draw:
  - Ignored; exactly 64 writes and one draw_done.
- resetn dropped at cycle 100 of a draw:
  - All outputs 0 immediately; no draw_done.
  - A subsequent start draws the full sprite correctly.
- 256 back-to-back draws:
  - draw_count wraps to 0.
  - clear_count asserted in the DONE cycle leaves draw_count=0.
- With DRAW_SPRITE_TRANSPARENT_EN and TKEY=0, ROM[0]=0, others nonzero:
  - 63 writes; pixel (x_init, y_init) is skipped; timing unchanged.

Source files
------------

// File: rtl/draw_sprite.sv
// Sprite blitter: walks an SPR_W x SPR_H ROM row-major, emitting one clipped pixel write every 3 cycles.
// Optional macro DRAW_SPRITE_TRANSPARENT_EN suppresses writes of pixels whose colour equals TKEY.
//
// state   | meaning
// IDLE    | waiting for start; anchor latched on accept
// ADDR    | rom_addr presented; pixel X/Y registered
// DATA    | ROM latency; colour and clip flag registered
// WRITE   | pixel write strobe (unless clipped/keyed); advance col/row
// DONE    | draw_done pulse; draw_count increments
module draw_sprite #(
  parameter int                 SPR_W    = 8,
  parameter int                 SPR_H    = 8,
  parameter int                 ADDR_W   = 6,
  parameter int                 COLOR_W  = 12,
  parameter int                 SCREEN_W = 320,
  parameter int                 SCREEN_H = 240,
  parameter logic [COLOR_W-1:0] TKEY     = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [8:0]         x_init,
  input  logic [7:0]         y_init,
  input  logic               clear_count,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [8:0]         X_out,
  output logic [7:0]         Y_out,
  output logic [COLOR_W-1:0] Color_out,
  output logic               writeEn,
  output logic               busy,
  output logic               draw_done,
  output logic [7:0]         draw_count
);

`ifdef DRAW_SPRITE_TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam logic [6:0] COL_LAST = 7'(SPR_W - 1);
  localparam logic [6:0] ROW_LAST = 7'(SPR_H - 1);
  localparam logic [9:0] X_LIM    = 10'(SCREEN_W);
  localparam logic [8:0] Y_LIM    = 9'(SCREEN_H);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE, S_DONE} state_t;

  state_t     state;
  logic [8:0] x_lat;
  logic [7:0] y_lat;
  logic [6:0] col;
  logic [6:0] row;
  logic       clip;

  logic [9:0] x_sum;
  logic [8:0] y_sum;
  logic       last_col;
  logic       last_pix;
  logic       key_hit;

  // Wide sums so off-screen pixels are detected instead of wrapping.
  assign x_sum    = {1'b0, x_lat} + {3'b000, col};
  assign y_sum    = {1'b0, y_lat} + {2'b00, row};
  assign last_col = (col == COL_LAST);
  assign last_pix = last_col && (row == ROW_LAST);
  assign key_hit  = (Color_out == TKEY);

  assign busy      = (state != S_IDLE);
  assign draw_done = (state == S_DONE);
  assign writeEn   = (state == S_WRITE) && !clip && !(TRANSP_EN && key_hit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      x_lat      <= '0;
      y_lat      <= '0;
      col        <= '0;
      row        <= '0;
      clip       <= 1'b0;
      rom_addr   <= '0;
      X_out      <= '0;
      Y_out      <= '0;
      Color_out  <= '0;
      draw_count <= '0;
    end else begin
      if (clear_count)
        draw_count <= '0;
      else if (state == S_DONE)
        draw_count <= draw_count + 8'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            x_lat    <= x_init;
            y_lat    <= y_init;
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          X_out <= x_sum[8:0];
          Y_out <= y_sum[7:0];
          state <= S_DATA;
        end
        S_DATA: begin
          Color_out <= rom_q;
          clip      <= (x_sum >= X_LIM) || (y_sum >= Y_LIM);
          state     <= S_WRITE;
        end
        S_WRITE: begin
          // Row-major walk: row*SPR_W + col is just a running increment.
          rom_addr <= rom_addr + ADDR_W'(1);
          if (last_col) begin
            col <= '0;
            row <= row + 7'd1;
          end else begin
            col <= col + 7'd1;
          end
          state <= last_pix ? S_DONE : S_ADDR;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
// Randomized bench for draw_sprite: a list-of-pixels model predicts every write, the draw_done cycle and draw_count.
module tb_draw_sprite;

`ifdef DRAW_SPRITE_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  localparam int W = 8, H = 8, NPIX = W * H, DONE_CYC = 3 * NPIX + 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x_init = '0;
  logic [7:0]  y_init = '0;
  logic        clear_count = 1'b0;
  logic [5:0]  rom_addr;
  logic [11:0] rom_q;
  logic [8:0]  X_out;
  logic [7:0]  Y_out;
  logic [11:0] Color_out;
  logic        writeEn, busy, draw_done;
  logic [7:0]  draw_count;

  logic [11:0] rom [NPIX];
  logic [28:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          exp_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  draw_sprite dut (
    .clk(clk), .resetn(resetn), .start(start), .x_init(x_init), .y_init(y_init),
    .clear_count(clear_count), .rom_addr(rom_addr), .rom_q(rom_q),
    .X_out(X_out), .Y_out(Y_out), .Color_out(Color_out), .writeEn(writeEn),
    .busy(busy), .draw_done(draw_done), .draw_count(draw_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_expected(input int x, input int y);
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int xs = x + c;
        int ys = y + r;
        logic [11:0] colr = rom[r * W + c];
        if (xs < 320 && ys < 240 && !(TRANSP && colr == 12'h000))
          exp_q.push_back({9'(xs), 8'(ys), colr});
      end
  endtask

  // restart_at / abort_at: cycle (1 = first cycle after accept) to re-pulse start / drop reset; 0 = never.
  task automatic do_draw(input int x, input int y, input int restart_at, input int abort_at,
                         input bit clr_at_done);
    int n, writes, done_cyc, exp_writes;
    build_expected(x, y);
    exp_writes = exp_q.size();
    @(negedge clk);
    check("idle_before_start", {31'd0, busy}, 32'd0);
    start = 1'b1; x_init = 9'(x); y_init = 8'(y);
    @(negedge clk);
    start = 1'b0;
    n = 1; writes = 0; done_cyc = 0;
    while (n <= DONE_CYC + 20 && done_cyc == 0) begin
      start = 1'b0;
      if (n == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (n == abort_at) begin
        resetn = 1'b0;
        #1;
        check("abort_outputs", {rom_addr, X_out, Y_out, writeEn, busy, draw_done},
              32'd0);
        check("abort_color_count", {Color_out, draw_count}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_count = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("abort_quiet", {30'd0, writeEn, draw_done}, 32'd0);
        end
        return;
      end
      if (writeEn) begin
        writes++;
        if (exp_q.size() == 0) check("extra_write", 32'd1, 32'd0);
        else check("pixel", {3'd0, X_out, Y_out, Color_out}, {3'd0, exp_q.pop_front()});
      end
      if (draw_done) begin
        done_cyc = n;
        clear_count = clr_at_done;
      end
      if (n == restart_at) start = 1'b1;
      @(negedge clk);
      n++;
    end
    clear_count = 1'b0;
    exp_count = clr_at_done ? 0 : (exp_count + 1) % 256;
    check("write_count", writes, exp_writes);
    check("done_cycle", done_cyc, DONE_CYC);
    check("draw_count", {24'd0, draw_count}, exp_count);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) rom[i] = 12'(i);
    #1;
    check("reset_state", {rom_addr, X_out, Y_out, writeEn, busy, draw_done}, 32'd0);
    check("reset_color_count", {Color_out, draw_count}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_draw(10, 20, 0, 0, 1'b0);
    do_draw(316, 236, 0, 0, 1'b0);
    do_draw(100, 50, 50, 0, 1'b0);
    do_draw(30, 40, 0, 100, 1'b0);
    do_draw(10, 20, 0, 0, 1'b0);

    @(negedge clk);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    exp_count = 0;
    check("clear_idle", {24'd0, draw_count}, 32'd0);

    for (int d = 0; d < 256; d++) begin
      for (int i = 0; i < NPIX; i++) rom[i] = 12'($urandom);
      do_draw($urandom_range(0, 340), $urandom_range(0, 250), 0, 0, 1'b0);
    end
    check("count_wrapped", {24'd0, draw_count}, 32'd0);

    do_draw($urandom_range(0, 319), $urandom_range(0, 239), 0, 0, 1'b0);
    do_draw($urandom_range(0, 319), $urandom_range(0, 239), 0, 0, 1'b1);
    check("clear_wins_at_done", {24'd0, draw_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
